// File: rtl/mips_alu_ctrl.sv
// rtl/mips_alu_ctrl.sv - MIPS ALU-control decode into a registered ID/EX issue stage (optional skid buffer: MIPS_ALU_CTRL_SKID_EN)
module mips_alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  alu_slct,
    output logic [1:0]  shft_op,
    output logic        arhmt_op,
    output logic        sign_ctrl,
    output logic [1:0]  logic_op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        illegal
);
    localparam int W = 73;

    logic [5:0]   w_op;
    logic [5:0]   w_funct;
    logic [31:0]  w_sext;
    logic [31:0]  w_zext;
    logic [1:0]   w_alu_slct;
    logic [1:0]   w_shft_op;
    logic         w_arhmt_op;
    logic         w_sign_ctrl;
    logic [1:0]   w_logic_op;
    logic [31:0]  w_a;
    logic [31:0]  w_b;
    logic         w_illegal;
    logic [W-1:0] w_dec;
    logic         w_push;
    logic         w_pop;
    logic         w_unused_fields;

    logic [W-1:0] r_out;
    logic         r_out_valid;

    assign w_op            = instr[31:26];
    assign w_funct         = instr[5:0];
    assign w_sext          = {{16{instr[15]}}, instr[15:0]};
    assign w_zext          = {16'b0, instr[15:0]};
    assign w_unused_fields = ^instr[25:16];

    // Decode op/funct into ALU unit select, sub-op, signedness and operands
    always_comb begin
        w_alu_slct  = 2'b00;
        w_shft_op   = 2'b00;
        w_arhmt_op  = 1'b0;
        w_sign_ctrl = 1'b0;
        w_logic_op  = 2'b00;
        w_a         = rs_data;
        w_b         = rt_data;
        w_illegal   = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h20: begin w_alu_slct = 2'b10; w_sign_ctrl = 1'b1; end
                    6'h21: begin w_alu_slct = 2'b10; end
                    6'h22: begin w_alu_slct = 2'b10; w_arhmt_op = 1'b1; w_sign_ctrl = 1'b1; end
                    6'h23: begin w_alu_slct = 2'b10; w_arhmt_op = 1'b1; end
                    6'h24: begin w_alu_slct = 2'b11; w_logic_op = 2'b00; end
                    6'h25: begin w_alu_slct = 2'b11; w_logic_op = 2'b01; end
                    6'h26: begin w_alu_slct = 2'b11; w_logic_op = 2'b10; end
                    6'h27: begin w_alu_slct = 2'b11; w_logic_op = 2'b11; end
                    6'h2A: begin w_alu_slct = 2'b01; w_arhmt_op = 1'b1; w_sign_ctrl = 1'b1; end
                    6'h2B: begin w_alu_slct = 2'b01; w_arhmt_op = 1'b1; end
                    6'h00: begin w_shft_op = 2'b00; w_a = {27'b0, instr[10:6]}; end
                    6'h02: begin w_shft_op = 2'b01; w_a = {27'b0, instr[10:6]}; end
                    6'h03: begin w_shft_op = 2'b10; w_a = {27'b0, instr[10:6]}; end
                    6'h04: begin w_shft_op = 2'b00; end
                    6'h06: begin w_shft_op = 2'b01; end
                    6'h07: begin w_shft_op = 2'b10; end
                    default: w_illegal = 1'b1;
                endcase
            end
            6'h08: begin w_alu_slct = 2'b10; w_sign_ctrl = 1'b1; w_b = w_sext; end
            6'h09: begin w_alu_slct = 2'b10; w_b = w_sext; end
            6'h0A: begin w_alu_slct = 2'b01; w_arhmt_op = 1'b1; w_sign_ctrl = 1'b1; w_b = w_sext; end
            6'h0B: begin w_alu_slct = 2'b01; w_arhmt_op = 1'b1; w_b = w_sext; end
            6'h0C: begin w_alu_slct = 2'b11; w_logic_op = 2'b00; w_b = w_zext; end
            6'h0D: begin w_alu_slct = 2'b11; w_logic_op = 2'b01; w_b = w_zext; end
            6'h0E: begin w_alu_slct = 2'b11; w_logic_op = 2'b10; w_b = w_zext; end
            6'h0F: begin w_shft_op = 2'b00; w_a = 32'd16; w_b = w_zext; end
            default: w_illegal = 1'b1;
        endcase
        // An unsupported word still issues, but carries no operation
        if (w_illegal) begin
            w_a = 32'b0;
            w_b = 32'b0;
        end
    end

    assign w_dec = {w_alu_slct, w_shft_op, w_arhmt_op, w_sign_ctrl, w_logic_op, w_a, w_b, w_illegal};
    assign {alu_slct, shft_op, arhmt_op, sign_ctrl, logic_op, a, b, illegal} = r_out;
    assign out_valid = r_out_valid;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = r_out_valid && out_ready;

`ifdef MIPS_ALU_CTRL_SKID_EN
    logic [W-1:0] r_skid;
    logic         r_skid_valid;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready
    assign in_ready = !rst && !r_skid_valid;

    // Output register backed by one skid entry that absorbs a word accepted during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_pop && r_skid_valid) begin
            r_out        <= r_skid;
            r_skid_valid <= 1'b0;
        end else if (w_push) begin
            if (!r_out_valid || w_pop) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end
`else
    // Accept when the output slot is empty or being drained this cycle
    assign in_ready = !rst && (!r_out_valid || out_ready);

    // Single ID/EX register; a push during a pop replaces the word with no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_push) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_mips_alu_ctrl.sv
// tb/tb_mips_alu_ctrl.sv - self-checking bench for mips_alu_ctrl
module tb_mips_alu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  alu_slct;
    logic [1:0]  shft_op;
    logic        arhmt_op;
    logic        sign_ctrl;
    logic [1:0]  logic_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;

    always #5 clk = ~clk;

    mips_alu_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_slct(alu_slct), .shft_op(shft_op), .arhmt_op(arhmt_op),
        .sign_ctrl(sign_ctrl), .logic_op(logic_op), .a(a), .b(b), .illegal(illegal)
    );

    typedef struct packed {
        logic [1:0]  alu_slct;
        logic [1:0]  shft_op;
        logic        arhmt_op;
        logic        sign_ctrl;
        logic [1:0]  logic_op;
        logic [31:0] a;
        logic [31:0] b;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic rst_seen = 1'b1;

`ifdef MIPS_ALU_CTRL_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // Reference: what the ALU must be told for one instruction
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [31:0] sx;
        logic [31:0] zx;
        logic        ok;
        e  = '0;
        ok = 1'b1;
        sx = 32'($signed(w[15:0]));
        zx = 32'(w[15:0]);
        e.a = rs;
        if (w[31:26] == 6'd0) begin
            e.b = rt;
            case (w[5:0])
                6'h20: begin e.alu_slct = 2; e.sign_ctrl = 1; end
                6'h21: begin e.alu_slct = 2; end
                6'h22: begin e.alu_slct = 2; e.arhmt_op = 1; e.sign_ctrl = 1; end
                6'h23: begin e.alu_slct = 2; e.arhmt_op = 1; end
                6'h24: begin e.alu_slct = 3; e.logic_op = 0; end
                6'h25: begin e.alu_slct = 3; e.logic_op = 1; end
                6'h26: begin e.alu_slct = 3; e.logic_op = 2; end
                6'h27: begin e.alu_slct = 3; e.logic_op = 3; end
                6'h2A: begin e.alu_slct = 1; e.arhmt_op = 1; e.sign_ctrl = 1; end
                6'h2B: begin e.alu_slct = 1; e.arhmt_op = 1; end
                6'h00: begin e.shft_op = 0; e.a = 32'(w[10:6]); end
                6'h02: begin e.shft_op = 1; e.a = 32'(w[10:6]); end
                6'h03: begin e.shft_op = 2; e.a = 32'(w[10:6]); end
                6'h04: e.shft_op = 0;
                6'h06: e.shft_op = 1;
                6'h07: e.shft_op = 2;
                default: ok = 1'b0;
            endcase
        end else begin
            case (w[31:26])
                6'h08: begin e.alu_slct = 2; e.sign_ctrl = 1; e.b = sx; end
                6'h09: begin e.alu_slct = 2; e.b = sx; end
                6'h0A: begin e.alu_slct = 1; e.arhmt_op = 1; e.sign_ctrl = 1; e.b = sx; end
                6'h0B: begin e.alu_slct = 1; e.arhmt_op = 1; e.b = sx; end
                6'h0C: begin e.alu_slct = 3; e.logic_op = 0; e.b = zx; end
                6'h0D: begin e.alu_slct = 3; e.logic_op = 1; e.b = zx; end
                6'h0E: begin e.alu_slct = 3; e.logic_op = 2; e.b = zx; end
                6'h0F: begin e.a = 16; e.b = zx; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            e = '0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // Every cycle: compare DUT against the queue model, then advance the model for the coming edge
    always @(negedge clk) begin
        exp_t got;
        logic exp_ready;
        got = {alu_slct, shft_op, arhmt_op, sign_ctrl, logic_op, a, b, illegal};
        n_vec++;
        if (rst_seen) begin
            if (out_valid !== 1'b0 || got !== '0) begin
                n_err++;
                $display("FAIL reset_state out_valid=%b fields=%h required 0/0", out_valid, got);
            end
        end else if (out_valid !== (q.size() != 0)) begin
            n_err++;
            $display("FAIL out_valid got=%b required=%b", out_valid, q.size() != 0);
        end else if (out_valid && got !== q[0]) begin
            n_err++;
            $display("FAIL issue_fields got=%h required=%h", got, q[0]);
        end
        exp_ready = !rst && ((q.size() < DEPTH) || (DEPTH == 1 && out_ready));
        n_vec++;
        if (in_ready !== exp_ready) begin
            n_err++;
            $display("FAIL in_ready got=%b required=%b", in_ready, exp_ready);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(instr, rs_data, rt_data));
        end
        rst_seen = rst;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    // Offer one word; returns one step after the accepting edge
    task automatic send(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        instr    = w;
        rs_data  = rs;
        rt_data  = rt;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL send_timeout instr=%h waited=%0d required<50", w, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);
        settle();

        // add $3,$1,$2
        send(32'h00221820, 32'd5, 32'd7, w);
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_slct", 32'(alu_slct), 2);
        chk("add_arhmt", 32'(arhmt_op), 0);
        chk("add_sign", 32'(sign_ctrl), 1);
        chk("add_a", a, 5);
        chk("add_b", b, 7);
        chk("add_ill", 32'(illegal), 0);
        settle();

        // sra $2,$1,4
        send(32'h00011103, 32'd9, 32'h80000000, w);
        @(negedge clk);
        chk("sra_slct", 32'(alu_slct), 0);
        chk("sra_shft", 32'(shft_op), 2);
        chk("sra_a", a, 4);
        chk("sra_b", b, 32'h80000000);
        settle();

        // lui $1,0x1234
        send(32'h3C011234, 32'h55, 32'h77, w);
        @(negedge clk);
        chk("lui_slct", 32'(alu_slct), 0);
        chk("lui_shft", 32'(shft_op), 0);
        chk("lui_a", a, 16);
        chk("lui_b", b, 32'h00001234);
        settle();

        // slti with imm = -1, then ori with the same immediate
        send(32'h2841FFFF, 32'd3, 32'd0, w);
        @(negedge clk);
        chk("slti_slct", 32'(alu_slct), 1);
        chk("slti_sign", 32'(sign_ctrl), 1);
        chk("slti_b", b, 32'hFFFFFFFF);
        settle();
        send(32'h3441FFFF, 32'd3, 32'd0, w);
        @(negedge clk);
        chk("ori_slct", 32'(alu_slct), 3);
        chk("ori_logic", 32'(logic_op), 1);
        chk("ori_b", b, 32'h0000FFFF);
        settle();

        // unsupported opcode 0x3F
        send(32'hFC000000, 32'h11, 32'h22, w);
        @(negedge clk);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_ctrl", {24'd0, alu_slct, shft_op, arhmt_op, sign_ctrl, logic_op}, 0);
        chk("ill_a", a, 0);
        chk("ill_b", b, 0);
        settle();

        // stall: three words offered while out_ready = 0
        out_ready = 1'b0;
        send(32'h00221821, 32'd1, 32'd2, w);
        @(negedge clk);
`ifdef MIPS_ALU_CTRL_SKID_EN
        chk("stall_ready_1", 32'(in_ready), 1);
        settle();
        send(32'h384100F0, 32'h0F0F, 32'd0, w);
        @(negedge clk);
        chk("stall_ready_2", 32'(in_ready), 0);
`else
        chk("stall_ready_1", 32'(in_ready), 0);
`endif
        settle();
        fork
            send(32'h00221006, 32'd3, 32'hF0000000, w);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_hold_a", a, 1);
                    chk("stall_hold_b", b, 2);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) settle();
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 0);
        chk("drain_valid", 32'(out_valid), 0);
        settle();

        // back-to-back stream at full rate
        for (int i = 0; i < 6; i++) begin
            send({6'h0, 5'(i), 5'(i + 1), 5'd2, 5'd0, 6'h22 + 6'(i % 6)}, 32'(i * 3), 32'(i + 100), w);
            chk("stream_no_wait", 32'(w), 0);
        end
        repeat (3) settle();

        // reset while a word is stalled: it must never be presented
        out_ready = 1'b0;
        send(32'h20210005, 32'd3, 32'd0, w);
        rst = 1'b1;
        settle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_valid", 32'(out_valid), 0);
        settle();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_never_shown", 32'(out_valid), 0);
        end
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_alu_ctrl.md
# mips_alu_ctrl

- Decode-to-execute issue stage that produces the ALU control fields and operands.
- Decodes the MIPS instruction word, selects and extends operands, then registers everything into the ID/EX boundary.
- Uses a valid/ready handshake on both sides, so the datapath ALU sees only registered, pipeline-aligned controls.
- Flags unsupported opcodes instead of silently issuing them.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and a 32-bit instruction.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds instr/rs_data/rt_data valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  MIPS instruction word
- rs_data  in  32  register-file rs value
- rt_data  in  32  register-file rt value
- out_valid  out  1  outputs below hold an issued operation
- out_ready  in  1  execute stage consumes this cycle
- alu_slct  out  2  00 shift, 01 set-less-than, 10 arithmetic, 11 logic
- shft_op  out  2  00 sll, 01 srl, 10 sra
- arhmt_op  out  1  0 add, 1 subtract
- sign_ctrl  out  1  1 signed (overflow/compare signed), 0 unsigned
- logic_op  out  2  00 and, 01 or, 10 xor, 11 nor
- a  out  32  operand A; for shifts, a[4:0] is the shift amount
- b  out  32  operand B; for shifts, b is the value shifted
- illegal  out  1  issued word is not a supported ALU instruction

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Fields: op = instr[31:26], funct = instr[5:0], shamt = instr[10:6], imm = instr[15:0].
- Sign-extended imm: sext = {{16{imm[15]}}, imm}. Zero-extended imm: zext = {16'b0, imm}.
- R-type decode (op 0x00), with a = rs_data and b = rt_data unless stated:
  - add 0x20 → 10/add/signed; addu 0x21 → 10/add/unsigned.
  - sub 0x22 → 10/sub/signed; subu 0x23 → 10/sub/unsigned.
  - and 0x24, or 0x25, xor 0x26, nor 0x27 → 11 with logic_op 00/01/10/11.
  - slt 0x2A → 01/signed; sltu 0x2B → 01/unsigned; arhmt_op = 1 for both.
  - sll 0x00, srl 0x02, sra 0x03 → 00 with shft_op 00/01/10; a = {27'b0, shamt}.
  - sllv 0x04, srlv 0x06, srav 0x07 → 00 with shft_op 00/01/10; a = rs_data.
- I-type decode, with a = rs_data:
  - addi 0x08 → 10/add/signed, b = sext.
  - addiu 0x09 → 10/add/unsigned, b = sext.
  - slti 0x0A → 01/signed, b = sext.
  - sltiu 0x0B → 01/unsigned, b = sext.
  - andi 0x0C, ori 0x0D, xori 0x0E → 11 with logic_op 00/01/10, b = zext.
  - lui 0x0F → 00/sll, a = 32'd16, b = zext.
- Any other op/funct issues normally with illegal = 1 and all controls, a and b zero.
- Fields not used by the selected unit are driven to 0.

## Timing
- Latency: a word accepted in cycle N appears on the outputs with out_valid = 1 in cycle N+1.
- Outputs are registered only. There is no combinational path from instr/rs_data/rt_data to any output.
- While out_valid = 1 && out_ready = 0, all outputs hold stable.
- Simultaneous pop and push in one cycle: the new word replaces the old one with no bubble.
- Reset, in the cycle rst is sampled high:
  - out_valid = 0 and in_ready = 0.
  - All control fields, a, b and illegal = 0.
  - Any held or in-flight word is discarded.
- First cycle after reset release: in_ready = 1.
- Back-to-back throughput: one instruction per cycle while out_ready = 1.

## Configuration
- MIPS_ALU_CTRL_SKID_EN defined:
  - Two-entry skid buffer; in_ready is a register, equal to !(skid entry occupied).
  - A word accepted while the output stalls lands in the skid entry.
  - The skid entry moves to the output on the next pop.
  - Full throughput with no combinational out_ready → in_ready path.
- MIPS_ALU_CTRL_SKID_EN undefined:
  - Single output register; in_ready = !out_valid || out_ready (combinational).

## Test plan
- add $3,$1,$2 (instr 0x00221820), rs = 5, rt = 7, out_ready = 1 → next cycle: out_valid = 1, alu_slct = 10, arhmt_op = 0, sign_ctrl = 1, a = 5, b = 7, illegal = 0.
- sra $2,$1,4 (instr 0x00011103), rt = 0x80000000 → alu_slct = 00, shft_op = 10, a = 4, b = 0x80000000.
- lui $1,0x1234 (instr 0x3C011234) → alu_slct = 00, shft_op = 00, a = 16, b = 0x00001234.
- Instructions 0x2841FFFF (slti, imm = -1) and 0x3441FFFF (ori) → slti issues b = 0xFFFFFFFF with sign_ctrl = 1; ori issues b = 0x0000FFFF with logic_op = 01.
- Hold out_ready = 0 for 3 cycles while streaming 3 words:
  - Outputs stay stable through the stall.
  - Skid build: in_ready drops after the 2nd accept.
  - Non-skid build: in_ready drops after the 1st accept.
  - On release, the words emerge in order with no loss or duplication.
- Edge cases:
  - Opcode 0x3F → illegal = 1, all controls zero.
  - rst asserted while a word is stalled → next cycle out_valid = 0 and the word is never presented.
